fp16_divider: RTL and testbench
===============================

// Module: fp16_divider
// PURPOSE
//   Iterative IEEE-754 binary16 divider (q = a / b), the inverse operation of the pipelined fp16 multiplier.
//   It is used where the array needs normalisation/reciprocal scaling. Valid/ready on both sides, one
//   operation in flight. Special-value encodings and round-to-nearest-even are bit-identical to the multiplier's.
// PARAMETERS
//   BITS_PER_CYCLE  1   quotient bits retired per DIV cycle; legal values 1 or 2 (elaboration error otherwise)
// PORTS
//   clk        in   1   clock; all state updates on posedge
//   rst        in   1   asynchronous, active-high reset
//   in_valid   in   1   operands a/b valid
//   in_ready   out  1   divider idle, can accept operands
//   a          in   16  dividend, fp16
//   b          in   16  divisor, fp16
//   out_valid  out  1   result valid; held until accepted
//   out_ready  in   1   consumer accepts result
//   out        out  16  quotient, fp16
// BEHAVIOUR
//   Reset: state=IDLE, in_ready=1, out_valid=0, out=16'h0000. Reset mid-operation abandons the operation silently.
//   Transfer happens on a posedge where valid&ready. in_ready=1 only in IDLE. a/b are registered at accept.
//   FSM: IDLE -(in accept)-> UNPACK -(special)-> DONE | -(normal)-> DIV -> ROUND -> DONE -(out accept)-> IDLE.
//   UNPACK (1 cyc): classify both operands. A subnormal operand is normalised by an 11-bit leading-zero count:
//     mant <<= lz, exp_eff = 1 - lz. A normal operand has mant = {1,frac} and exp_eff = exp.
//     e = exp_a - exp_b + 15 (signed, 8b). sign = sa ^ sb.
//   Specials, in priority order:
//     NaN | 0/0 | inf/inf       -> 16'h7E00, sign ignored
//     inf/x | x/0               -> {sign,15'h7C00}
//     0/x | x/inf               -> {sign,15'h0000}
//   DIV: restoring division of 11b mant_a by 11b mant_b. It produces QW=14 quotient bits in 14/BITS_PER_CYCLE cycles.
//     sticky = (final remainder != 0).
//   ROUND (1 cyc):
//     If q[13]=0 (ratio < 1): shift q left by 1 and decrement e.
//     If e <= 0: right-shift the 14b q by (1-e), OR all shifted-out bits into sticky, set e=0.
//       Shift amount is capped at 15, after which q=0 and sticky=|q.
//     RNE on the guard/round/sticky bits; lsb is the 11-bit mantissa lsb.
//     Rounding carry-out: a subnormal becomes the minimum normal; a normal renormalises with e+1.
//     e >= 31 after rounding -> {sign,15'h7C00}.
//   out_valid rises the posedge after ROUND, or after UNPACK for specials.
//     Normal latency, accept edge to out_valid: 2 + 14/BITS_PER_CYCLE cycles (16 or 9).
//     Special latency: 2 cycles.
//   out and out_valid hold stable while out_ready=0. in_valid is ignored outside IDLE.
//   The cycle after out accept is IDLE with in_ready=1; there is no same-cycle back-to-back turnaround.
// CONFIGURATION
//   FP16_DIV_FTZ_EN defined:
//     Subnormal inputs are treated as signed zero in UNPACK.
//     Any result that would be subnormal after rounding is returned as {sign,15'h0000}.
//     The LZC normaliser and the denorm shifter are removed.
//   Not defined: full gradual underflow as described above.
// STRUCTURE
//   Package fp16_pkg: FP16_BIAS=15, FP16_EXP_W=5, FP16_FRAC_W=10, FP16_QNAN=16'h7E00, FP16_INF=15'h7C00,
//     fp16_div_state_t {IDLE,UNPACK,DIV,ROUND,DONE}.
//   Sub-module fp16_lzc11: combinational 11-bit leading-zero count (4b output). It is instantiated twice in UNPACK,
//     and omitted under FP16_DIV_FTZ_EN.
//   All other logic (FSM, iteration, round/pack) lives in this module.
// TESTING
//   3C00/4000 (1/2): -> 3800, out_valid exactly 16 cycles after accept (BPC=1) and 9 (BPC=2);
//     in_ready=0 throughout.
//   3C00/4200 (1/3): -> 3555 (RNE, sticky set).
//   C500/3C00: -> C500. 7BFF/3800: -> 7C00 (overflow).
//   Specials: 0000/0000 -> 7E00; 7C00/7C00 -> 7E00; 3C00/8000 -> FC00; 8000/4000 -> 8000; 7E01/3C00 -> 7E00.
//   Underflow: 0400/4000 -> 0200; 0001/3C00 -> 0001; 0001/4000 -> 0000 (tie to even).
//     With FP16_DIV_FTZ_EN: 0400/4000 -> 0000; 0001/3C00 -> 0000.
//   Handshake:
//     Hold out_ready=0 for 5 cycles -> out stable, in_ready=0, a new in_valid is ignored.
//     Assert rst during DIV -> next cycle in_ready=1, out_valid=0, out=0000.

Source files
------------

// File: rtl/fp16_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | fp16_pkg : shared binary16 constants and divider state encoding             |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package fp16_pkg;

  localparam int          FP16_BIAS   = 15;
  localparam int          FP16_EXP_W  = 5;
  localparam int          FP16_FRAC_W = 10;
  localparam logic [15:0] FP16_QNAN   = 16'h7E00;
  localparam logic [14:0] FP16_INF    = 15'h7C00;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    DIV    = 3'd2,
    ROUND  = 3'd3,
    DONE   = 3'd4
  } fp16_div_state_t;

endpackage
`default_nettype wire

// File: rtl/fp16_lzc11.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | fp16_lzc11 : combinational 11-bit leading-zero counter (11 for all-zero)    |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module fp16_lzc11 (
  input  logic [10:0] x_i,
  output logic [3:0]  lz_o
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    lz_o = 4'd11;
    for (int i = 0; i < 11; i++) begin
      if (x_i[i]) lz_o = 4'(10 - i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp16_divider.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | fp16_divider : iterative IEEE-754 binary16 divider, RNE, valid/ready both   |
// | sides. Define FP16_DIV_FTZ_EN to flush subnormal inputs and results.        |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module fp16_divider
  import fp16_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out
);

  localparam int         QW       = 14;
  localparam int         DIV_CYC  = QW / BITS_PER_CYCLE;
  localparam logic [3:0] DIV_LAST = 4'(DIV_CYC - 1);

  if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2) begin : g_bpc_check
    $error("fp16_divider: BITS_PER_CYCLE must be 1 or 2");
  end

  fp16_div_state_t   state_q;
  logic [15:0]       a_q, b_q, out_q;
  logic              sign_q, out_valid_q, in_ready_q;
  logic signed [7:0] e_q;
  logic [10:0]       mb_q;
  logic [11:0]       rem_q;
  logic [13:0]       quo_q;
  logic [3:0]        cnt_q;

  // ---------------- unpack / classify ----------------
  logic [4:0]        exp_a, exp_b;
  logic [9:0]        frac_a, frac_b;
  logic              a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
  logic [10:0]       ma_d, mb_d;
  logic signed [7:0] ea_d, eb_d, e_d;
  logic              sign_d, spec_hit;
  logic [15:0]       spec_d;

  assign exp_a  = a_q[FP16_FRAC_W +: FP16_EXP_W];
  assign exp_b  = b_q[FP16_FRAC_W +: FP16_EXP_W];
  assign frac_a = a_q[FP16_FRAC_W-1:0];
  assign frac_b = b_q[FP16_FRAC_W-1:0];
  assign a_nan  = (exp_a == 5'h1F) && (frac_a != 10'd0);
  assign a_inf  = (exp_a == 5'h1F) && (frac_a == 10'd0);
  assign b_nan  = (exp_b == 5'h1F) && (frac_b != 10'd0);
  assign b_inf  = (exp_b == 5'h1F) && (frac_b == 10'd0);
  assign sign_d = a_q[15] ^ b_q[15];

`ifdef FP16_DIV_FTZ_EN
  assign a_zero = (exp_a == 5'd0);
  assign b_zero = (exp_b == 5'd0);
  assign ma_d   = {1'b1, frac_a};
  assign mb_d   = {1'b1, frac_b};
  assign ea_d   = $signed({3'b000, exp_a});
  assign eb_d   = $signed({3'b000, exp_b});
`else
  logic [3:0] lz_a, lz_b;

  fp16_lzc11 u_lzc_a (.x_i({1'b0, frac_a}), .lz_o(lz_a));
  fp16_lzc11 u_lzc_b (.x_i({1'b0, frac_b}), .lz_o(lz_b));

  assign a_zero = (exp_a == 5'd0) && (frac_a == 10'd0);
  assign b_zero = (exp_b == 5'd0) && (frac_b == 10'd0);
  assign ma_d   = (exp_a == 5'd0) ? ({1'b0, frac_a} << lz_a) : {1'b1, frac_a};
  assign mb_d   = (exp_b == 5'd0) ? ({1'b0, frac_b} << lz_b) : {1'b1, frac_b};
  assign ea_d   = (exp_a == 5'd0) ? 8'sd1 - $signed({4'b0000, lz_a}) : $signed({3'b000, exp_a});
  assign eb_d   = (exp_b == 5'd0) ? 8'sd1 - $signed({4'b0000, lz_b}) : $signed({3'b000, exp_b});
`endif

  assign e_d = ea_d - eb_d + $signed(8'(FP16_BIAS));

  always_comb begin
    spec_hit = 1'b1;
    spec_d   = FP16_QNAN;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) spec_d = FP16_QNAN;
    else if (a_inf || b_zero)                                      spec_d = {sign_d, FP16_INF};
    else if (a_zero || b_inf)                                      spec_d = {sign_d, 15'h0000};
    else                                                           spec_hit = 1'b0;
  end

  // ---------------- restoring division step ----------------
  logic [11:0] rem_d;
  logic [13:0] quo_d;

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (rem_d >= {1'b0, mb_q}) begin
        rem_d = rem_d - {1'b0, mb_q};
        quo_d = {quo_d[12:0], 1'b1};
      end else begin
        quo_d = {quo_d[12:0], 1'b0};
      end
      rem_d = rem_d << 1;
    end
  end

  // ---------------- normalise / denormalise / round / pack ----------------
  logic [13:0]       qn, qs;
  logic signed [7:0] en, e2;
  logic              stk, up, sub;
  logic [11:0]       m12;
  logic [9:0]        frac_r;
  logic [15:0]       res_d;

`ifndef FP16_DIV_FTZ_EN
  logic [3:0]  sh;
  logic [28:0] wide;
`endif

  always_comb begin
    qn  = quo_q[13] ? quo_q : {quo_q[12:0], 1'b0};
    en  = quo_q[13] ? e_q : e_q - 8'sd1;
    stk = |rem_q;
    qs  = qn;
    sub = 1'b0;
`ifndef FP16_DIV_FTZ_EN
    sh   = 4'd0;
    wide = '0;
    if (en <= 8'sd0) begin
      sub  = 1'b1;
      sh   = (en < -8'sd14) ? 4'd15 : 4'(8'sd1 - en);
      // The extra 15 low bits catch everything shifted past the lsb.
      wide = {qn, 15'd0} >> sh;
      qs   = wide[28:15];
      stk  = stk | (|wide[14:0]);
    end
`endif
    up     = qs[2] & (qs[3] | qs[1] | qs[0] | stk);
    m12    = {1'b0, qs[13:3]} + {11'd0, up};
    e2     = m12[11] ? en + 8'sd1 : en;
    frac_r = m12[11] ? m12[10:1] : m12[9:0];
    if (sub)                 res_d = {sign_q, 4'd0, m12[10:0]};
    else if (e2 >= 8'sd31)   res_d = {sign_q, FP16_INF};
`ifdef FP16_DIV_FTZ_EN
    // Only an all-ones mantissa at e=0 would round up into the normal range.
    else if (en <= 8'sd0)    res_d = (en == 8'sd0 && (&qn[13:3])) ? {sign_q, 5'd1, 10'd0}
                                                                    : {sign_q, 15'h0000};
`endif
    else                     res_d = {sign_q, e2[4:0], frac_r};
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      out_q       <= '0;
      sign_q      <= 1'b0;
      e_q         <= '0;
      mb_q        <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            in_ready_q <= 1'b0;
            state_q    <= UNPACK;
          end
        end
        UNPACK: begin
          sign_q <= sign_d;
          e_q    <= e_d;
          mb_q   <= mb_d;
          rem_q  <= {1'b0, ma_d};
          quo_q  <= '0;
          cnt_q  <= DIV_LAST;
          if (spec_hit) begin
            out_q   <= spec_d;
            state_q <= DONE;
          end else begin
            state_q <= DIV;
          end
        end
        DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd0) state_q <= ROUND;
        end
        ROUND: begin
          out_q       <= res_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          // Special results arrive with out_valid still low; raise it one cycle later.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule
`default_nettype wire

// File: tb/tb_fp16_divider.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_fp16_divider : directed table, handshake/reset sequences and random ops  |
// | against a real-arithmetic binary16 reference. Rev 1.0                       |
// +-----------------------------------------------------------------------------+
module tb_fp16_divider;

  localparam int BPC   = 1;
  localparam int LAT_N = 2 + 14 / BPC;
  localparam int LAT_S = 2;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp16_divider #(.BITS_PER_CYCLE(BPC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic real p2(input int n);
    real r;
    r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else        for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real fval(input logic [15:0] x);
    int e, f;
    e = int'(x[14:10]);
    f = int'(x[9:0]);
    if (e == 0) return $itor(f) * p2(-24);
    return $itor(1024 + f) * p2(e - 25);
  endfunction

  function automatic int rne(input real x);
    real fl;
    int  i;
    fl = $floor(x);
    i  = $rtoi(fl);
    if ((x - fl) > 0.5 || ((x - fl) == 0.5 && (i % 2) == 1)) i++;
    return i;
  endfunction

  function automatic logic [14:0] enc(input real v);
    int m, e;
    if (v >= 65520.0) return 15'h7C00;
    if (v < p2(-14)) begin
      m = rne(v * p2(24));
      return 15'(m);
    end
    e = -14;
    while (v >= p2(e + 1)) e++;
    m = rne(v * p2(10 - e));
    if (m == 2048) begin
      m = 1024;
      e++;
    end
    if (e > 15) return 15'h7C00;
    return {5'(e + 15), 10'(m - 1024)};
  endfunction

  // Returns {special, result}.
  function automatic logic [16:0] ref_div(input logic [15:0] x, input logic [15:0] y);
    logic        s;
    bit          xn, yn, xi, yi, xz, yz;
    logic [14:0] mag;
    s  = x[15] ^ y[15];
    xn = (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    yn = (y[14:10] == 5'h1F) && (y[9:0] != 10'd0);
    xi = (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
    yi = (y[14:10] == 5'h1F) && (y[9:0] == 10'd0);
`ifdef FP16_DIV_FTZ_EN
    xz = (x[14:10] == 5'd0);
    yz = (y[14:10] == 5'd0);
`else
    xz = (x[14:0] == 15'd0);
    yz = (y[14:0] == 15'd0);
`endif
    if (xn || yn || (xz && yz) || (xi && yi)) return {1'b1, 16'h7E00};
    if (xi || yz) return {1'b1, s, 15'h7C00};
    if (xz || yi) return {1'b1, s, 15'h0000};
    mag = enc(fval(x) / fval(y));
`ifdef FP16_DIV_FTZ_EN
    if (mag[14:10] == 5'd0) mag = 15'h0000;
`endif
    return {1'b0, s, mag};
  endfunction

  // ---------------- transaction driver ----------------
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb2,
                        output logic [15:0] res, output int lat, output bit rdy_seen);
    @(negedge clk);
    a = ta; b = tb2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    res = out;
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL timeout: out_valid never rose for %h/%h", ta, tb2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] res, ra, rb;
    logic [16:0] m;
    int          lat, k;
    bit          rdy;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_out", out, 16'h0000);
    @(negedge clk) rst = 1'b0;

    vecs[0]  = '{16'h3C00, 16'h4000, 16'h3800, LAT_N};
    vecs[1]  = '{16'h3C00, 16'h4200, 16'h3555, LAT_N};
    vecs[2]  = '{16'hC500, 16'h3C00, 16'hC500, LAT_N};
    vecs[3]  = '{16'h7BFF, 16'h3800, 16'h7C00, LAT_N};
    vecs[4]  = '{16'h0000, 16'h0000, 16'h7E00, LAT_S};
    vecs[5]  = '{16'h7C00, 16'h7C00, 16'h7E00, LAT_S};
    vecs[6]  = '{16'h3C00, 16'h8000, 16'hFC00, LAT_S};
    vecs[7]  = '{16'h8000, 16'h4000, 16'h8000, LAT_S};
    vecs[8]  = '{16'h7E01, 16'h3C00, 16'h7E00, LAT_S};
`ifdef FP16_DIV_FTZ_EN
    vecs[9]  = '{16'h0400, 16'h4000, 16'h0000, LAT_N};
    vecs[10] = '{16'h0001, 16'h3C00, 16'h0000, LAT_S};
    vecs[11] = '{16'h0001, 16'h4000, 16'h0000, LAT_S};
`else
    vecs[9]  = '{16'h0400, 16'h4000, 16'h0200, LAT_N};
    vecs[10] = '{16'h0001, 16'h3C00, 16'h0001, LAT_N};
    vecs[11] = '{16'h0001, 16'h4000, 16'h0000, LAT_N};
`endif

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].a, vecs[i].b, res, lat, rdy);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 16'(lat), 16'(vecs[i].lat));
      check($sformatf("vec%0d_busy", i), 16'(rdy), 16'd0);
    end

    // Output back-pressure: result must hold and new operands must be ignored.
    @(negedge clk);
    a = 16'h3C00; b = 16'h4000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("hs_valid_rose", 16'(out_valid), 16'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 16'h4400; b = 16'h3C00; in_valid = 1'b1;
      @(posedge clk); #1;
      check($sformatf("hs_hold%0d_out", i), out, 16'h3800);
      check($sformatf("hs_hold%0d_valid", i), 16'(out_valid), 16'd1);
      check($sformatf("hs_hold%0d_in_ready", i), 16'(in_ready), 16'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hs_after_accept_valid", 16'(out_valid), 16'd0);
    check("hs_after_accept_in_ready", 16'(in_ready), 16'd1);
    @(posedge clk); #1;
    check("hs_no_ghost_valid", 16'(out_valid), 16'd0);
    check("hs_no_ghost_in_ready", 16'(in_ready), 16'd1);

    // Reset while iterating abandons the operation.
    @(negedge clk);
    a = 16'h3C00; b = 16'h4200; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("rst_div_in_ready", 16'(in_ready), 16'd1);
    check("rst_div_out_valid", 16'(out_valid), 16'd0);
    check("rst_div_out", out, 16'h0000);
    @(negedge clk) rst = 1'b0;
    run_op(16'h3C00, 16'h4000, res, lat, rdy);
    check("rst_recover_result", res, 16'h3800);

    // Random operands against the reference model.
    for (int n = 0; n < 150; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case (n % 4)
        1: begin
          ra[14:10] = 5'($urandom_range(10, 20));
          rb[14:10] = 5'($urandom_range(10, 20));
        end
        2: begin
          ra[14:10] = 5'($urandom_range(0, 4));
          rb[14:10] = 5'($urandom_range(14, 22));
        end
        3: ra[14:10] = 5'd0;
        default: ;
      endcase
      m = ref_div(ra, rb);
      run_op(ra, rb, res, lat, rdy);
      check($sformatf("rand%0d_%h_%h_result", n, ra, rb), res, m[15:0]);
      check($sformatf("rand%0d_latency", n), 16'(lat), m[16] ? 16'(LAT_S) : 16'(LAT_N));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
